// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port arbiter and sequencer in front of a data memory
// with combinational read and posedge write. Each granted access takes three
// cycles (handshake, memory access, response pulse).
// Optional feature: define DATA_MEM_ARB_MISALIGN_CHECK_EN to reject misaligned
// or reserved-size requests with resp_err instead of writing memory.
module data_mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_0,
    input  logic                  req_valid_1,
    output logic                  req_ready_0,
    output logic                  req_ready_1,
    input  logic [ADDR_WIDTH-1:0] req_addr_0,
    input  logic [ADDR_WIDTH-1:0] req_addr_1,
    input  logic [31:0]           req_wdata_0,
    input  logic [31:0]           req_wdata_1,
    input  logic [1:0]            req_size_0,
    input  logic [1:0]            req_size_1,
    input  logic                  req_unsigned_0,
    input  logic                  req_unsigned_1,
    input  logic                  req_we_0,
    input  logic                  req_we_1,
    output logic                  resp_valid_0,
    output logic                  resp_valid_1,
    output logic [31:0]           resp_rdata_0,
    output logic [31:0]           resp_rdata_1,
    output logic                  resp_err_0,
    output logic                  resp_err_1,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [31:0]           mem_wd,
    output logic [1:0]            mem_size,
    output logic                  mem_unsigned,
    output logic                  mem_we,
    input  logic [31:0]           mem_rd
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  lastGrant_q, lastGrant_d;
    logic                  port_q, port_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [1:0]            size_q, size_d;
    logic                  unsigned_q, unsigned_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;
    logic [31:0]           rdata_q, rdata_d;

    logic                  grantValid;
    logic                  grantPort;
    logic                  handshake;
    logic [ADDR_WIDTH-1:0] selAddr;
    logic [31:0]           selWdata;
    logic [1:0]            selSize;
    logic                  selUnsigned;
    logic                  selWe;
    logic                  reqErr;

    // Pick the port to serve: a lone requester wins, ties go round-robin or to port 0.
    always_comb begin
        grantValid = 1'b0;
        grantPort  = 1'b0;
        if (req_valid_0 && req_valid_1) begin
            grantValid = 1'b1;
            grantPort  = (FIXED_PRIORITY != 0) ? 1'b0 : ~lastGrant_q;
        end else if (req_valid_0) begin
            grantValid = 1'b1;
            grantPort  = 1'b0;
        end else if (req_valid_1) begin
            grantValid = 1'b1;
            grantPort  = 1'b1;
        end
    end

    assign handshake   = rst_n && (state_q == IDLE) && grantValid;
    assign req_ready_0 = handshake && !grantPort;
    assign req_ready_1 = handshake && grantPort;

    assign selAddr     = grantPort ? req_addr_1     : req_addr_0;
    assign selWdata    = grantPort ? req_wdata_1    : req_wdata_0;
    assign selSize     = grantPort ? req_size_1     : req_size_0;
    assign selUnsigned = grantPort ? req_unsigned_1 : req_unsigned_0;
    assign selWe       = grantPort ? req_we_1       : req_we_0;

`ifdef DATA_MEM_ARB_MISALIGN_CHECK_EN
    // Flag halves on odd addresses, words off a 4-byte boundary and the reserved size.
    always_comb begin
        reqErr = (selSize == 2'b11)
              || ((selSize == 2'b01) && selAddr[0])
              || ((selSize == 2'b10) && (selAddr[1:0] != 2'b00));
    end
`else
    assign reqErr = 1'b0;
`endif

    // Sequence IDLE -> ACCESS -> RESP, latching the request and the memory read-back.
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        port_d      = port_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        we_d        = we_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    port_d      = grantPort;
                    lastGrant_d = grantPort;
                    addr_d      = selAddr;
                    wdata_d     = selWdata;
                    size_d      = selSize;
                    unsigned_d  = selUnsigned;
                    we_d        = selWe;
                    err_d       = reqErr;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                rdata_d = err_q ? 32'h0 : mem_rd;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched-request registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
            port_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            size_q      <= 2'b10;
            unsigned_q  <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            port_q      <= port_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            we_q        <= we_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
        end
    end

    // Memory address/data hold the last latched request; write only during ACCESS.
    assign mem_a        = addr_q;
    assign mem_wd       = wdata_q;
    assign mem_size     = size_q;
    assign mem_unsigned = unsigned_q;
    assign mem_we       = (state_q == ACCESS) && we_q && !err_q;

    assign resp_valid_0 = (state_q == RESP) && !port_q;
    assign resp_valid_1 = (state_q == RESP) && port_q;
    assign resp_rdata_0 = resp_valid_0 ? rdata_q : 32'h0;
    assign resp_rdata_1 = resp_valid_1 ? rdata_q : 32'h0;
    assign resp_err_0   = resp_valid_0 && err_q;
    assign resp_err_1   = resp_valid_1 && err_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: scoreboard bench for data_mem_arbiter with a byte-array
// data memory model. Honours DATA_MEM_ARB_MISALIGN_CHECK_EN when defined.
module tb_data_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        valid0, valid1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [1:0]  size0, size1;
    logic        uns0, uns1, we0, we1;

    logic        req_ready_0, req_ready_1;
    logic        resp_valid_0, resp_valid_1;
    logic [31:0] resp_rdata_0, resp_rdata_1;
    logic        resp_err_0, resp_err_1;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic [1:0]  mem_size;
    logic        mem_unsigned, mem_we;

    logic        fxReady0, fxReady1, fxRespValid0, fxRespValid1, fxErr0, fxErr1;
    logic        fxMemUnsigned, fxMemWe;
    logic [31:0] fxRdata0, fxRdata1, fxMemA, fxMemWd;
    logic [1:0]  fxMemSize;

    bit   [7:0]  memBytes [0:255];
    int          cyc;
    int          vectors;
    int          fails;
    logic        contention;
    int          grantLog[$];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t expQ0[$];
    exp_t expQ1[$];

    data_mem_arbiter #(.ADDR_WIDTH(32), .FIXED_PRIORITY(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(valid0), .req_valid_1(valid1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_addr_0(addr0), .req_addr_1(addr1),
        .req_wdata_0(wdata0), .req_wdata_1(wdata1),
        .req_size_0(size0), .req_size_1(size1),
        .req_unsigned_0(uns0), .req_unsigned_1(uns1),
        .req_we_0(we0), .req_we_1(we1),
        .resp_valid_0(resp_valid_0), .resp_valid_1(resp_valid_1),
        .resp_rdata_0(resp_rdata_0), .resp_rdata_1(resp_rdata_1),
        .resp_err_0(resp_err_0), .resp_err_1(resp_err_1),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .mem_we(mem_we), .mem_rd(mem_rd)
    );

    data_mem_arbiter #(.ADDR_WIDTH(32), .FIXED_PRIORITY(1)) fixedDut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(valid0), .req_valid_1(valid1),
        .req_ready_0(fxReady0), .req_ready_1(fxReady1),
        .req_addr_0(addr0), .req_addr_1(addr1),
        .req_wdata_0(wdata0), .req_wdata_1(wdata1),
        .req_size_0(size0), .req_size_1(size1),
        .req_unsigned_0(uns0), .req_unsigned_1(uns1),
        .req_we_0(we0), .req_we_1(we1),
        .resp_valid_0(fxRespValid0), .resp_valid_1(fxRespValid1),
        .resp_rdata_0(fxRdata0), .resp_rdata_1(fxRdata1),
        .resp_err_0(fxErr0), .resp_err_1(fxErr1),
        .mem_a(fxMemA), .mem_wd(fxMemWd), .mem_size(fxMemSize),
        .mem_unsigned(fxMemUnsigned), .mem_we(fxMemWe), .mem_rd(32'h0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Little-endian data memory: combinational read with sign/zero extension.
    always_comb begin
        logic [7:0] a;
        a = mem_a[7:0];
        case (mem_size)
            2'b00:   mem_rd = mem_unsigned ? {24'h0, memBytes[a]}
                                           : {{24{memBytes[a][7]}}, memBytes[a]};
            2'b01:   mem_rd = mem_unsigned ? {16'h0, memBytes[a + 8'd1], memBytes[a]}
                                           : {{16{memBytes[a + 8'd1][7]}}, memBytes[a + 8'd1], memBytes[a]};
            default: mem_rd = {memBytes[a + 8'd3], memBytes[a + 8'd2], memBytes[a + 8'd1], memBytes[a]};
        endcase
    end

    // Memory write at the posedge closing a cycle with mem_we high.
    always @(posedge clk) begin
        if (mem_we) begin
            memBytes[mem_a[7:0]] <= mem_wd[7:0];
            if (mem_size != 2'b00) memBytes[mem_a[7:0] + 8'd1] <= mem_wd[15:8];
            if (mem_size[1]) begin
                memBytes[mem_a[7:0] + 8'd2] <= mem_wd[23:16];
                memBytes[mem_a[7:0] + 8'd3] <= mem_wd[31:24];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Present a request on one port and hold it until handshake; record the expected response.
    task automatic applyStimulus(input bit port, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [1:0] size, input logic uns, input logic we,
                                 input logic [31:0] expRdata, input logic expErr, input bit track);
        bit   hs;
        exp_t e;
        hs = 0;
        if (port == 1'b0) begin
            addr0 = addr; wdata0 = wdata; size0 = size; uns0 = uns; we0 = we; valid0 = 1'b1;
        end else begin
            addr1 = addr; wdata1 = wdata; size1 = size; uns1 = uns; we1 = we; valid1 = 1'b1;
        end
        for (int i = 0; i < 30 && !hs; i++) begin
            @(negedge clk);
            if ((port == 1'b0) ? req_ready_0 : req_ready_1) begin
                hs      = 1;
                e.rdata = expRdata;
                e.err   = expErr;
                e.cyc   = cyc;
                grantLog.push_back(int'(port));
                if (track) begin
                    if (port == 1'b0) expQ0.push_back(e);
                    else              expQ1.push_back(e);
                end
            end
        end
        if (!hs) begin
            vectors++;
            fails++;
            $display("[TB] FAIL handshakeTimeout: port %0d got no ready within 30 cycles", port);
        end
        @(posedge clk);
        #1;
        if (port == 1'b0) valid0 = 1'b0;
        else              valid1 = 1'b0;
    endtask

    // Called right after a handshake: check the one-cycle write window.
    task automatic checkWe(input logic expWe, input logic [31:0] expAddr);
        @(negedge clk);
        checkOutput("memWeAccess", {31'h0, mem_we}, {31'h0, expWe});
        checkOutput("memAddrAccess", mem_a, expAddr);
        @(negedge clk);
        checkOutput("memWeResp", {31'h0, mem_we}, 32'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "Ready0"}, {31'h0, req_ready_0}, 32'h0);
        checkOutput({tag, "Ready1"}, {31'h0, req_ready_1}, 32'h0);
        checkOutput({tag, "RespValid0"}, {31'h0, resp_valid_0}, 32'h0);
        checkOutput({tag, "RespValid1"}, {31'h0, resp_valid_1}, 32'h0);
        checkOutput({tag, "MemWe"}, {31'h0, mem_we}, 32'h0);
        checkOutput({tag, "MemA"}, mem_a, 32'h0);
        checkOutput({tag, "MemWd"}, mem_wd, 32'h0);
        checkOutput({tag, "MemSize"}, {30'h0, mem_size}, 32'h2);
        checkOutput({tag, "MemUnsigned"}, {31'h0, mem_unsigned}, 32'h0);
    endtask

    // Scoreboard monitor: every response pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (resp_valid_0) begin
            if (expQ0.size() == 0) checkOutput("resp0Unexpected", {31'h0, resp_valid_0}, 32'h0);
            else begin
                e = expQ0.pop_front();
                checkOutput("resp0Rdata", resp_rdata_0, e.rdata);
                checkOutput("resp0Err", {31'h0, resp_err_0}, {31'h0, e.err});
                checkOutput("resp0Latency", cyc, e.cyc + 2);
            end
        end else begin
            checkOutput("resp0IdleRdata", resp_rdata_0, 32'h0);
            checkOutput("resp0IdleErr", {31'h0, resp_err_0}, 32'h0);
        end
        if (resp_valid_1) begin
            if (expQ1.size() == 0) checkOutput("resp1Unexpected", {31'h0, resp_valid_1}, 32'h0);
            else begin
                e = expQ1.pop_front();
                checkOutput("resp1Rdata", resp_rdata_1, e.rdata);
                checkOutput("resp1Err", {31'h0, resp_err_1}, {31'h0, e.err});
                checkOutput("resp1Latency", cyc, e.cyc + 2);
            end
        end else begin
            checkOutput("resp1IdleRdata", resp_rdata_1, 32'h0);
            checkOutput("resp1IdleErr", {31'h0, resp_err_1}, 32'h0);
        end
    end

    // Fixed-priority instance must never grant port 1 while port 0 is requesting.
    always @(negedge clk) begin
        if (contention && valid0 && (fxReady0 || fxReady1)) begin
            checkOutput("fixedPrioReady1", {31'h0, fxReady1}, 32'h0);
            checkOutput("fixedPrioReady0", {31'h0, fxReady0}, 32'h1);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors = 0; fails = 0; cyc = 0; contention = 1'b0;
        valid0 = 0; valid1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        size0 = 0; size1 = 0; uns0 = 0; uns1 = 0; we0 = 0; we1 = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetValues("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Port 0 word store then load back.
        applyStimulus(1'b0, 32'h0, 32'hDEADBEEF, 2'b10, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
        checkWe(1'b1, 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1);

        // Port 1 byte store, signed and unsigned loads.
        applyStimulus(1'b1, 32'h4, 32'h000000A5, 2'b00, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
        checkWe(1'b1, 32'h4);
        applyStimulus(1'b1, 32'h4, 32'h0, 2'b00, 1'b0, 1'b0, 32'hFFFFFFA5, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h4, 32'h0, 2'b00, 1'b1, 1'b0, 32'h000000A5, 1'b0, 1'b1);

        // Both ports continuously valid after reset: round-robin 0,1,0,1,0,1.
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        grantLog.delete();
        contention = 1'b1;
        fork
            begin
                for (int i = 0; i < 3; i++)
                    applyStimulus(1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1);
            end
            begin
                for (int j = 0; j < 3; j++)
                    applyStimulus(1'b1, 32'h4, 32'h0, 2'b00, 1'b1, 1'b0, 32'h000000A5, 1'b0, 1'b1);
            end
        join
        contention = 1'b0;
        checkOutput("rrGrantCount", grantLog.size(), 32'd6);
        for (int k = 0; k < 6 && k < grantLog.size(); k++)
            checkOutput("rrGrantOrder", grantLog[k], k % 2);

        // Same-cycle half store (port 0) and signed half load (port 1).
        grantLog.delete();
        fork
            applyStimulus(1'b0, 32'h8, 32'h00008001, 2'b01, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
            applyStimulus(1'b1, 32'h8, 32'h0, 2'b01, 1'b0, 1'b0, 32'hFFFF8001, 1'b0, 1'b1);
        join
        checkOutput("halfFirstGrant", grantLog.size() > 0 ? grantLog[0] : -1, 32'd0);
        checkOutput("halfSecondGrant", grantLog.size() > 1 ? grantLog[1] : -1, 32'd1);
        repeat (3) @(posedge clk);
        #1;

        // Reset during ACCESS of a port 1 load: no response, outputs back to reset values.
        applyStimulus(1'b1, 32'h8, 32'h0, 2'b10, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkResetValues("midReset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(1'b1, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        // Misaligned word store to 0x2, then read word 0 back.
`ifdef DATA_MEM_ARB_MISALIGN_CHECK_EN
        applyStimulus(1'b0, 32'h2, 32'h12345678, 2'b10, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1);
        checkWe(1'b0, 32'h2);
        applyStimulus(1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1);
`else
        applyStimulus(1'b0, 32'h2, 32'h12345678, 2'b10, 1'b0, 1'b1, 32'h00A5DEAD, 1'b0, 1'b1);
        checkWe(1'b1, 32'h2);
        applyStimulus(1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 32'h5678BEEF, 1'b0, 1'b1);
`endif

        repeat (4) @(negedge clk);
        checkOutput("scoreboardDrained", expQ0.size() + expQ1.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of data_memory (combinational read, write on clk posedge).
- Port 0 serves the core load/store unit; port 1 serves a secondary master (DMA/debug loader).
- Grants one access at a time, registers the request, drives the memory for exactly one cycle, then returns the registered read data with a one-cycle response pulse.

Parameters:
- ADDR_WIDTH, 32, width of requester and memory addresses.
- FIXED_PRIORITY, 0: 0 = round-robin between ports; 1 = port 0 always wins when both are valid.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst_n  in  1  synchronous active-low reset, sampled on clk posedge.
- req_valid_0 / req_valid_1  in  1  request pending on port 0 / 1.
- req_ready_0 / req_ready_1  out  1  request accepted this cycle (combinational from state, round-robin pointer and valids).
- req_addr_0 / req_addr_1  in  ADDR_WIDTH  byte address.
- req_wdata_0 / req_wdata_1  in  32  write data, low bits used for byte/half.
- req_size_0 / req_size_1  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned_0 / req_unsigned_1  in  1  1 zero-extend, 0 sign-extend loads.
- req_we_0 / req_we_1  in  1  1 store, 0 load.
- resp_valid_0 / resp_valid_1  out  1  one-cycle response pulse.
- resp_rdata_0 / resp_rdata_1  out  32  read data, valid when resp_valid is high (stores return the memory read-back).
- resp_err_0 / resp_err_1  out  1  access rejected (see Optional Feature).
- mem_a  out  ADDR_WIDTH  to data_memory a.
- mem_wd  out  32  to data_memory wd.
- mem_size  out  2  to data_memory data_size.
- mem_unsigned  out  1  to data_memory data_unsigned.
- mem_we  out  1  to data_memory we.
- mem_rd  in  32  from data_memory rd.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; last_grant=1, so port 0 wins the first tie.
  - Outputs: req_ready_*=0; resp_valid_*=0; resp_rdata_*=0; resp_err_*=0; mem_we=0; mem_a=0; mem_wd=0; mem_size=2'b10; mem_unsigned=0.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - If no valid, stay.
  - If exactly one port is valid, grant it.
  - If both are valid: grant the port not equal to last_grant (FIXED_PRIORITY=0), or port 0 (FIXED_PRIORITY=1).
  - req_ready_x=1 only for the granted port, and only in IDLE.
  - On the handshake: latch addr/wdata/size/unsigned/we and the port id; update last_grant; go to ACCESS.
- ACCESS (one cycle):
  - mem_* driven from the latched fields; mem_we=latched we.
  - Memory write occurs at the closing posedge; mem_rd is captured into the response register at that posedge. Go to RESP.
- RESP (one cycle):
  - resp_valid_x=1 and resp_rdata_x=captured data for the granted port only; the other port's outputs hold 0.
  - mem_we=0. Go to IDLE.
- Latency: handshake in cycle N, memory access in N+1, resp_valid in N+2, next handshake no earlier than N+3. Maximum throughput is one access per 3 cycles.
- mem_we is high only in ACCESS; outside ACCESS, mem_a/mem_wd/mem_size/mem_unsigned hold their last values.
- A valid dropped before its handshake is legal; nothing is issued for it.
- A valid held during ACCESS/RESP is not accepted until IDLE.
- Starvation bound (round-robin): a continuously valid port is granted within 2 grants.
- Reset mid-operation (ACCESS or RESP): return to IDLE next cycle, no resp_valid, mem_we=0. A store in ACCESS at the reset edge is not guaranteed written.
- resp_rdata_* is zeroed whenever resp_valid_* is low.

Optional Feature:
- Macro: DATA_MEM_ARB_MISALIGN_CHECK_EN.
- Defined: on handshake, a request is an error if:
  - size=01 with addr[0]=1, or
  - size=10 with addr[1:0]!=0, or
  - size=11.
  - Error requests still pass through ACCESS, but mem_we is forced to 0. In RESP: resp_err_x=1, resp_rdata_x=0.
- Undefined: resp_err_* tied to 0; every request is passed to memory unchanged, and size=11 is forwarded as-is.

Test Plan:
- Port 0 word store addr 0x0, wdata 0xDEADBEEF, then word load addr 0x0 -> first resp_valid_0 two cycles after each handshake; load returns 0xDEADBEEF; mem_we high for exactly one cycle.
- Port 1 byte store 0xA5 to addr 0x4, then signed load -> 0xFFFFFFA5; then unsigned load -> 0x000000A5.
- Both ports valid continuously, FIXED_PRIORITY=0 -> grants alternate 0,1,0,1 starting with 0; with FIXED_PRIORITY=1 -> port 1 is never granted while port 0 is valid.
- Port 0 half store 0x8001 to addr 0x8, port 1 signed half load from 0x8 the same cycle -> port 0 served first; port 1 returns 0xFFFF8001 at its resp.
- rst_n pulled low during ACCESS of a port 1 load -> no resp_valid_1; all outputs at reset values; next request is granted from IDLE.
- With DATA_MEM_ARB_MISALIGN_CHECK_EN: word store to 0x2 -> resp_err=1, rdata=0, mem_we stays 0, and a word at 0x0 is unchanged. Without the macro: resp_err=0 and mem_we=1 for that store.
